// File: rtl/apb_m_if.sv
// -----------------------------------------------------------------------------
// apb_m_if
// Bundles the command/response handshake and the APB bus of the apb_m
// requester into one interface.
//
//   command  : cmd_valid, cmd_ready, cmd_write, cmd_addr, cmd_wdata
//   response : rsp_valid, rsp_rdata, rsp_err, rsp_tmo
//   APB      : paddr, psel, penable, pwrite, pwdata, prdata, pready, pslverr
//
// Modports
//   master : view of the apb_m block itself. It receives commands and drives
//            the APB request signals.
//   slave  : view of the environment. It issues commands and plays the APB
//            completer.
// -----------------------------------------------------------------------------
interface apb_m_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 8
);
   // command / response side
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_tmo;
   // APB side
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
      output paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo,
      input  paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/apb_m.sv
// -----------------------------------------------------------------------------
// apb_m
// APB requester. It accepts one command at a time on a valid/ready handshake
// and runs it as an APB SETUP + ACCESS transfer. It honours pready wait states
// and returns a one-cycle response pulse carrying the read data and the
// pslverr status.
//
// Ports
//   pclk    : clock, rising edge
//   preset  : asynchronous, active-high reset
//   bus     : apb_m_if.master. This carries the command handshake
//             (cmd_valid/ready/write/addr/wdata), the response
//             (rsp_valid/rdata/err/tmo) and the APB signals
//             (paddr, psel, penable, pwrite, pwdata, prdata, pready, pslverr).
//
// Parameters
//   ADDR_W  : address width
//   DATA_W  : data width
//   TIMEOUT : count of ACCESS cycles with pready low that triggers an abort.
//             Used only when the watchdog is compiled in. Must be >= 1.
//
// Build option
//   APB_M_TIMEOUT_EN : define this macro to compile in the ACCESS watchdog.
//                      Without it, ACCESS waits forever and rsp_tmo is 0.
//
// Every output is a flop. Output next-values are decoded from the next state,
// so psel, penable and cmd_ready line up with the state they describe.
// -----------------------------------------------------------------------------
module apb_m #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic     pclk,
   input  logic     preset,
   apb_m_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Latched command. It drives paddr/pwrite/pwdata directly and holds its
   // value until the next handshake.
   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   // Response payload. It is only meaningful while rsp_valid is high and
   // holds its value otherwise.
   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } rsp_t;

   state_t state_q, state_d;
   cmd_t   cmd_q,   cmd_d;
   rsp_t   rsp_q,   rsp_d;
   logic   rsp_vld_q, rsp_vld_d;
   logic   psel_q,    psel_d;
   logic   penable_q, penable_d;
   logic   rdy_q,     rdy_d;

   logic   hs;
   logic   done;
   logic   abort;

   // The handshake uses the registered ready, so no command can be taken in
   // the cycle between reset release and the first clock edge.
   assign hs   = (state_q == IDLE) && bus.cmd_valid && rdy_q;
   assign done = (state_q == ACCESS) && bus.pready;

`ifdef APB_M_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;

   // The abort fires on the edge where the stall count would reach TIMEOUT.
   // A pready in that same cycle takes priority, so the transfer completes.
   assign abort = (state_q == ACCESS) && !bus.pready && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      tmo_d = tmo_q;
      if (state_q == SETUP)
         cnt_d = '0;
      else if ((state_q == ACCESS) && !bus.pready)
         cnt_d = cnt_q + 1'b1;
      if (done)
         tmo_d = 1'b0;
      else if (abort)
         tmo_d = 1'b1;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign bus.rsp_tmo = tmo_q;
`else
   assign abort       = 1'b0;
   assign bus.rsp_tmo = 1'b0;
`endif

   // next state, next command latch, next response
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      rsp_d     = rsp_q;
      rsp_vld_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (hs) begin
               cmd_d.write = bus.cmd_write;
               cmd_d.addr  = bus.cmd_addr;
               // pwdata is 0 during reads
               cmd_d.wdata = bus.cmd_write ? bus.cmd_wdata : '0;
               state_d     = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (done) begin
               rsp_vld_d   = 1'b1;
               rsp_d.err   = bus.pslverr;
               // read data is kept even when pslverr is set
               rsp_d.rdata = cmd_q.write ? '0 : bus.prdata;
               state_d     = IDLE;
            end else if (abort) begin
               rsp_vld_d   = 1'b1;
               rsp_d.err   = 1'b1;
               rsp_d.rdata = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state, then registered.
   always_comb begin
      psel_d    = (state_d != IDLE);
      penable_d = (state_d == ACCESS);
      rdy_d     = (state_d == IDLE);
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q   <= IDLE;
         cmd_q     <= '0;
         rsp_q     <= '0;
         rsp_vld_q <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         rsp_q     <= rsp_d;
         rsp_vld_q <= rsp_vld_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         rdy_q     <= rdy_d;
      end
   end

   assign bus.cmd_ready = rdy_q;
   assign bus.rsp_valid = rsp_vld_q;
   assign bus.rsp_rdata = rsp_q.rdata;
   assign bus.rsp_err   = rsp_q.err;
   assign bus.paddr     = cmd_q.addr;
   assign bus.pwrite    = cmd_q.write;
   assign bus.pwdata    = cmd_q.wdata;
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;

endmodule

// File: doc/apb_m.md
# apb_m

APB requester (master) that turns a single-entry command/response handshake into APB SETUP/ACCESS transfers toward an 8-bit-data, 16-entry APB slave with error reporting. It sits between a local controller or test sequencer and the APB bus. It holds address, control and write data stable for the whole transfer, honours `pready` wait states, and returns read data plus `pslverr` status. An optional watchdog aborts transfers whose slave never asserts `pready`.

## Interface
Parameters:
- ADDR_W, 32, width of `paddr` / `cmd_addr`
- DATA_W, 8, width of `pwdata` / `prdata` / command and response data
- TIMEOUT, 16, number of consecutive ACCESS cycles with `pready`=0 before abort; only used when the watchdog is compiled in; must be ≥1

Ports:
- pclk  in  1  clock; all state changes on rising edge
- preset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when `cmd_valid` && `cmd_ready`
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
- rsp_err  out  1  `pslverr` sampled at completion, or timeout
- rsp_tmo  out  1  transfer aborted by the watchdog
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data; 0 during reads
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

## Operation
- **States:** IDLE, SETUP, ACCESS. All outputs are registered.
- **IDLE**
  - `cmd_ready`=1, `psel`=0, `penable`=0.
  - On handshake: latch `cmd_addr`, `cmd_write` and `cmd_wdata` (forced to 0 if read), then go to SETUP.
  - `cmd_*` are sampled only on the handshake cycle.
- **SETUP**
  - `psel`=1, `penable`=0, `cmd_ready`=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel`=1, `penable`=1.
  - If `pready`=1:
    - Register `rsp_valid`=1 and `rsp_err`=`pslverr`.
    - `rsp_rdata` = `prdata` for reads, 0 for writes. Read data is captured even when `pslverr`=1.
    - Go to IDLE.
  - If `pready`=0: stay in ACCESS. `paddr`, `pwrite` and `pwdata` stay unchanged.
- **Bus hold:** `paddr`, `pwrite` and `pwdata` keep their last values in IDLE. They change only at a handshake.
- **No response queue:** `cmd_valid` outside IDLE is ignored.
- **Response fields:** `rsp_rdata`, `rsp_err` and `rsp_tmo` are valid only while `rsp_valid`=1. They hold their values otherwise.
- **Back-to-back commands:** `cmd_valid` held high is accepted in the IDLE cycle that coincides with `rsp_valid`.

## Timing
- **Reset:** while `preset`=1, asynchronously:
  - state = IDLE
  - all outputs = 0, except `cmd_ready`, which is 0 during reset and 1 in the first cycle after release
- **Reset mid-transfer:** `psel` and `penable` drop immediately. No response is produced and the command is lost.
- **Cycle sequence** (handshake at edge 0):
  - cycle 1: SETUP
  - cycle 2: first ACCESS
  - zero wait states: `rsp_valid`=1 in cycle 3, and `cmd_ready`=1 in the same cycle
- **Latency:** 3 + N cycles from handshake to `rsp_valid`, where N is the number of wait cycles with `pready`=0.
- **Throughput:** minimum 3 cycles per transfer. `psel` drops for one cycle between transfers.
- **Watchdog:**
  - The counter clears on entering ACCESS and increments each ACCESS cycle with `pready`=0.
  - Abort occurs at the edge where the count reaches TIMEOUT.
  - If `pready`=1 arrives in that same cycle, normal completion wins.

## Configuration
- Macro: `APB_M_TIMEOUT_EN`.
- **Defined:**
  - The watchdog is active.
  - On abort: go to IDLE and pulse `rsp_valid` with `rsp_err`=1, `rsp_tmo`=1, `rsp_rdata`=0.
- **Undefined:**
  - No counter logic.
  - ACCESS waits indefinitely for `pready`.
  - `rsp_tmo` is tied to 0.

## Test plan
- **Write, no wait:** write addr 5, data 0xA5, `pready`=1 in the first ACCESS cycle.
  - `psel`=1 for 2 cycles, `penable`=1 for 1 cycle, `pwdata`=0xA5, `paddr`=5.
  - `rsp_valid` in cycle 3 with `rsp_err`=0 and `rsp_rdata`=0.
- **Read with 3 wait states:** read addr 5, `pready` low for 3 ACCESS cycles, then high with `prdata`=0x3C.
  - Address and control stable throughout; `pwdata`=0.
  - `rsp_rdata`=0x3C, `rsp_valid` at cycle 6.
- **Slave error:** read addr 20, slave returns `pready`=1 and `pslverr`=1.
  - `rsp_err`=1, `rsp_tmo`=0.
- **Timeout:** TIMEOUT=4, macro defined, `pready` stuck at 0.
  - After 4 ACCESS cycles: `psel`=0, `rsp_valid`=1, `rsp_err`=1, `rsp_tmo`=1.
  - Macro undefined: `psel` and `penable` stay 1 for 50 cycles.
- **Reset mid-ACCESS:** assert `preset` during ACCESS.
  - `psel`/`penable` go to 0 asynchronously, and `rsp_valid` never pulses.
  - After release, `cmd_ready`=1 and a new write completes normally.
- **Back-to-back:** `cmd_valid` held high for write addr 1 then read addr 1.
  - Second handshake occurs in the cycle with the first `rsp_valid`.
  - Read returns the written data from a slave model.
